wfg_wb_regbank: RTL and testbench
=================================

WFG_WB_REGBANK -- requirements
Module: wfg_wb_regbank

Interface
REQ-001 SHALL have parameter BUSW, default 32: Wishbone data width, a multiple of 8.
REQ-002 SHALL have parameter NREGS, default 8: number of registers, 1..64.
REQ-003 SHALL have parameter ADDRW, default 12: decoded address bits.
REQ-004 SHALL have parameter MODES, default all RW: packed 2-bit mode per register (RW, RO, W1C, SHADOW).
REQ-005 SHALL have parameter RESET_VAL, default 0: packed NREGS*BUSW reset values.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: wb_clk_i and wb_rst_ni.
REQ-007 wb_clk_i  in  1  clock.
REQ-008 wb_rst_ni  in  1  async active-low reset.
REQ-009 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable.
REQ-010 wbs_sel_i  in  BUSW/8  byte-lane select.
REQ-011 wbs_dat_i  in  BUSW  write data.
REQ-012 wbs_adr_i  in  BUSW  byte address; only [ADDRW-1:0] decoded.
REQ-013 wbs_ack_o  out  1  transfer acknowledge.
REQ-014 wbs_err_o  out  1  transfer error.
REQ-015 wbs_dat_o  out  BUSW  registered read data.
REQ-016 hw_rd_i  in  NREGS*BUSW  live values for RO registers.
REQ-017 hw_set_i  in  NREGS*BUSW  per-bit set pulses for W1C registers.
REQ-018 commit_i  in  1  single-cycle copy of all SHADOW staging values to active.
REQ-019 reg_q_o  out  NREGS*BUSW  active register values.
REQ-020 reg_wr_o  out  NREGS  one-cycle pulse per register written.

Function
REQ-021 Register i SHALL sit at byte offset 4*i; index = wbs_adr_i[ADDRW-1:2].
REQ-022 A request SHALL be accepted on a rising edge where stb & cyc & ~ack & ~err; the response SHALL follow on the next cycle (latency 1).
REQ-023 Ack or err SHALL be high for exactly one cycle per accepted request; a held strobe SHALL produce a new response every second cycle.
REQ-024 Index >= NREGS, or wbs_adr_i[1:0] != 0, SHALL raise err instead of ack, perform no write, and return dat 0.
REQ-025 RW write SHALL update only the byte lanes whose sel bit is set; sel = 0 SHALL ack with no change.
REQ-026 RO write SHALL be acked and ignored; RO read SHALL return hw_rd_i sampled on the accept edge.
REQ-027 W1C bits SHALL set on hw_set_i; a write of 1 on a selected lane SHALL clear the bit; a simultaneous set and clear SHALL leave the bit set.
REQ-028 SHADOW write SHALL update the staging register only; reads SHALL return staging; commit_i SHALL copy all staging to active on the next edge.
REQ-029 A write and commit_i in the same cycle SHALL load the newly written value into active.
REQ-030 reg_wr_o[i] SHALL pulse in the ack cycle of every accepted non-error write to register i, RO registers included.
REQ-031 wbs_dat_o SHALL hold 0 whenever ack is low.

Reset
REQ-032 On wb_rst_ni low, immediately: ack, err, dat_o and reg_wr_o SHALL be 0; RW, W1C, staging and active registers SHALL take RESET_VAL.
REQ-033 Reset during a pending response SHALL drop that response; no ack SHALL appear after release until a new accept.
REQ-034 Reset release SHALL be synchronised by the integrator; the block SHALL not rely on release timing.

Structure
REQ-035 Package wfg_wb_regbank_pkg SHALL hold the reg_mode_e enum (RW=0, RO=1, W1C=2, SHADOW=3) and the stride constant.
REQ-036 Sub-module wfg_wb_regbank_cell SHALL implement one BUSW register with mode-dependent write, set, clear and commit logic, generated NREGS times.

Verification
REQ-037 Reset, then read reg 0 with RESET_VAL[0] = 32'h0000_4000 -> ack one cycle later, dat 32'h0000_4000, err 0.
REQ-038 RW write 32'hAABB_CCDD with sel 4'b0101 to reg value 0 -> readback 32'h00BB_00DD; reg_wr_o[i] pulses once.
REQ-039 Read offset 4*NREGS, then offset 0x002 -> err pulse for each, no ack, dat 0, no register change.
REQ-040 W1C: hw_set bit 3 while software writes 32'h8 in the same cycle -> bit 3 stays 1; next write of 32'h8 -> bit 3 reads 0.
REQ-041 SHADOW: write 32'h1234 -> reg_q_o unchanged; commit_i pulse -> reg_q_o = 32'h1234; write 32'h5678 with commit_i same cycle -> active = 32'h5678.
REQ-042 Strobe held 6 cycles -> exactly 3 ack pulses; reset asserted mid-response -> ack drops immediately and does not reappear.

Source files
------------

// File: rtl/wfg_wb_regbank_pkg.sv
// Shared types and constants for the Wishbone register bank.
package wfg_wb_regbank_pkg;

    // Per-register access behaviour, packed two bits per register in MODES.
    typedef enum logic [1:0] {
        RW     = 2'd0,
        RO     = 2'd1,
        W1C    = 2'd2,
        SHADOW = 2'd3
    } reg_mode_e;

    // Registers are word aligned: one register every four bytes.
    localparam int REG_STRIDE      = 4;
    localparam int REG_STRIDE_LOG2 = 2;

endpackage

// File: rtl/wfg_wb_regbank_cell.sv
// One BUSW-wide register whose write, set, clear and commit behaviour is
// chosen by MODE. RO cells keep no state of their own; they expose hw_val.
module wfg_wb_regbank_cell
    import wfg_wb_regbank_pkg::*;
#(
    parameter int               BUSW      = 32,
    parameter reg_mode_e        MODE      = RW,
    parameter logic [BUSW-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BUSW-1:0]   wr_data,
    input  logic [BUSW-1:0]   wr_mask,
    input  logic [BUSW-1:0]   set_bits,
    input  logic [BUSW-1:0]   hw_val,
    input  logic              commit,
    output logic [BUSW-1:0]   rd_q,
    output logic [BUSW-1:0]   act_q
);

    logic [BUSW-1:0] stage_q;
    logic [BUSW-1:0] active_q;
    logic [BUSW-1:0] merged;
    logic [BUSW-1:0] clr_bits;

    // Byte-lane merge of write data into the staged value.
    assign merged   = (stage_q & ~wr_mask) | (wr_data & wr_mask);
    assign clr_bits = wr_en ? (wr_data & wr_mask) : '0;

    // Mode-dependent update; for W1C the set term is OR-ed last so it wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q  <= RESET_VAL;
            active_q <= RESET_VAL;
        end else begin
            case (MODE)
                RW: begin
                    if (wr_en) stage_q <= merged;
                end
                W1C: begin
                    stage_q <= (stage_q & ~clr_bits) | set_bits;
                end
                SHADOW: begin
                    if (wr_en) stage_q <= merged;
                    if (commit) active_q <= wr_en ? merged : stage_q;
                end
                default: begin
                end
            endcase
        end
    end

    // Bus reads see staging for SHADOW; the active copy drives the fabric.
    assign rd_q  = (MODE == RO) ? hw_val : stage_q;
    assign act_q = (MODE == RO)     ? hw_val :
                   (MODE == SHADOW) ? active_q : stage_q;

endmodule

// File: rtl/wfg_wb_regbank.sv
// Wishbone slave register bank: NREGS word-aligned registers with per-register
// RW / RO / W1C / SHADOW behaviour and a single-cycle registered response.
module wfg_wb_regbank
    import wfg_wb_regbank_pkg::*;
#(
    parameter int                     BUSW      = 32,
    parameter int                     NREGS     = 8,
    parameter int                     ADDRW     = 12,
    parameter logic [2*NREGS-1:0]     MODES     = '0,
    parameter logic [NREGS*BUSW-1:0]  RESET_VAL = '0
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [BUSW/8-1:0]        wbs_sel_i,
    input  logic [BUSW-1:0]          wbs_dat_i,
    input  logic [BUSW-1:0]          wbs_adr_i,
    output logic                     wbs_ack_o,
    output logic                     wbs_err_o,
    output logic [BUSW-1:0]          wbs_dat_o,
    input  logic [NREGS*BUSW-1:0]    hw_rd_i,
    input  logic [NREGS*BUSW-1:0]    hw_set_i,
    input  logic                     commit_i,
    output logic [NREGS*BUSW-1:0]    reg_q_o,
    output logic [NREGS-1:0]         reg_wr_o
);

    localparam int IDXW = ADDRW - REG_STRIDE_LOG2;
    localparam int NSEL = BUSW / 8;

    logic [IDXW-1:0]   idx;
    logic [31:0]       idx_ext;
    logic              accept;
    logic              bad_addr;
    logic              wr_accept;
    logic [BUSW-1:0]   wr_mask;
    logic [BUSW-1:0]   rd_data;
    logic [NREGS-1:0]  wr_en;
    logic [BUSW-1:0]   rd_val [NREGS];
    logic              unused_adr;

    // Address bits above the decoded window are deliberately ignored.
    assign unused_adr = ^wbs_adr_i[BUSW-1:ADDRW];

    assign idx       = wbs_adr_i[ADDRW-1:REG_STRIDE_LOG2];
    assign idx_ext   = 32'(idx);
    assign bad_addr  = (idx_ext >= NREGS) || (wbs_adr_i[REG_STRIDE_LOG2-1:0] != '0);
    // A pending response blocks acceptance, so a held strobe is served every other cycle.
    assign accept    = wbs_stb_i && wbs_cyc_i && !wbs_ack_o && !wbs_err_o;
    assign wr_accept = accept && !bad_addr && wbs_we_i;

    // Expand byte-lane selects into a bit mask.
    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < NSEL; b++) begin
            wr_mask[b*8 +: 8] = {8{wbs_sel_i[b]}};
        end
    end

    // Decode the accepted write onto a single register.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NREGS; i++) begin
            wr_en[i] = wr_accept && (idx_ext == i);
        end
    end

    // Select the read value of the addressed register.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx_ext == i) rd_data = rd_val[i];
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        localparam reg_mode_e MODE = reg_mode_e'(MODES[2*g +: 2]);

        wfg_wb_regbank_cell #(
            .BUSW      (BUSW),
            .MODE      (MODE),
            .RESET_VAL (RESET_VAL[g*BUSW +: BUSW])
        ) u_cell (
            .clk      (wb_clk_i),
            .rst_n    (wb_rst_ni),
            .wr_en    (wr_en[g]),
            .wr_data  (wbs_dat_i),
            .wr_mask  (wr_mask),
            .set_bits (hw_set_i[g*BUSW +: BUSW]),
            .hw_val   (hw_rd_i[g*BUSW +: BUSW]),
            .commit   (commit_i),
            .rd_q     (rd_val[g]),
            .act_q    (reg_q_o[g*BUSW +: BUSW])
        );
    end

    // Registered response: ack or err one cycle after accept, data only on read acks.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
            reg_wr_o  <= '0;
        end else begin
            wbs_ack_o <= accept && !bad_addr;
            wbs_err_o <= accept && bad_addr;
            wbs_dat_o <= (accept && !bad_addr && !wbs_we_i) ? rd_data : '0;
            reg_wr_o  <= wr_en;
        end
    end

endmodule

// File: tb/tb_wfg_wb_regbank.sv
// Scoreboard bench for wfg_wb_regbank: directed scenarios plus random traffic
// checked against a behavioural register model.
module tb_wfg_wb_regbank;
    import wfg_wb_regbank_pkg::*;

    localparam int BUSW  = 32;
    localparam int NREGS = 8;
    localparam int ADDRW = 12;
    // reg0 RW, reg1 RW, reg2 RO, reg3 W1C, reg4 SHADOW, reg5 RW, reg6 W1C, reg7 SHADOW
    localparam logic [2*NREGS-1:0] TB_MODES =
        {2'd3, 2'd2, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    localparam logic [NREGS*BUSW-1:0] TB_RESET =
        {32'hCAFE_0000, 32'h00FF_0000, 32'h1234_5678, 32'h0000_0000,
         32'h0000_00F0, 32'h5555_AAAA, 32'h0000_0000, 32'h0000_4000};

    logic                    clk    = 1'b0;
    logic                    rst_n  = 1'b0;
    logic                    stb    = 1'b0;
    logic                    cyc    = 1'b0;
    logic                    we     = 1'b0;
    logic [3:0]              sel    = '0;
    logic [31:0]             dat_i  = '0;
    logic [31:0]             adr    = '0;
    logic [NREGS*BUSW-1:0]   hw_rd  = '0;
    logic [NREGS*BUSW-1:0]   hw_set = '0;
    logic                    commit = 1'b0;
    logic                    ack;
    logic                    err;
    logic [31:0]             dat_o;
    logic [NREGS*BUSW-1:0]   reg_q;
    logic [NREGS-1:0]        reg_wr;

    typedef struct {
        int          due;
        bit          is_err;
        bit          chk_dat;
        logic [31:0] dat;
        logic [7:0]  wr;
    } exp_t;

    exp_t        sb_q[$];
    int          tests   = 0;
    int          fails   = 0;
    int          cyc_cnt = 0;
    int          ack_cnt = 0;
    logic [31:0] m_stage  [NREGS];
    logic [31:0] m_active [NREGS];
    bit          m_busy;

    wfg_wb_regbank #(
        .BUSW      (BUSW),
        .NREGS     (NREGS),
        .ADDRW     (ADDRW),
        .MODES     (TB_MODES),
        .RESET_VAL (TB_RESET)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_err_o (err),
        .wbs_dat_o (dat_o),
        .hw_rd_i   (hw_rd),
        .hw_set_i  (hw_set),
        .commit_i  (commit),
        .reg_q_o   (reg_q),
        .reg_wr_o  (reg_wr)
    );

    always #5 clk = ~clk;

    function automatic reg_mode_e mode_of(input int i);
        return reg_mode_e'(TB_MODES[2*i +: 2]);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one request in flight at a time, response one cycle later.
    always @(posedge clk or negedge rst_n) begin : model_p
        bit          acc;
        bit          bad;
        bit          hit;
        int          idx;
        logic [31:0] mask;
        logic [31:0] merged;
        exp_t        e;
        cyc_cnt++;
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                m_stage[i]  = TB_RESET[i*32 +: 32];
                m_active[i] = TB_RESET[i*32 +: 32];
            end
            m_busy = 1'b0;
            sb_q.delete();
        end else begin
            acc = stb && cyc && !m_busy;
            idx = int'(adr[ADDRW-1:2]);
            bad = (idx >= NREGS) || (adr[1:0] != 2'b00);
            for (int b = 0; b < 4; b++) mask[b*8 +: 8] = sel[b] ? 8'hFF : 8'h00;
            if (acc) begin
                e.due     = cyc_cnt;
                e.is_err  = bad;
                e.chk_dat = bad || !we;
                e.dat     = '0;
                e.wr      = '0;
                if (!bad && !we)
                    e.dat = (mode_of(idx) == RO) ? hw_rd[idx*32 +: 32] : m_stage[idx];
                if (!bad && we)
                    e.wr = 8'(1 << idx);
                sb_q.push_back(e);
            end
            for (int i = 0; i < NREGS; i++) begin
                hit    = acc && !bad && we && (idx == i);
                merged = (m_stage[i] & ~mask) | (dat_i & mask);
                case (mode_of(i))
                    RW:     if (hit) m_stage[i] = merged;
                    W1C:    m_stage[i] = (m_stage[i] & ~(hit ? (dat_i & mask) : 32'h0))
                                         | hw_set[i*32 +: 32];
                    SHADOW: begin
                        if (hit) m_stage[i] = merged;
                        if (commit) m_active[i] = m_stage[i];
                    end
                    default: begin
                    end
                endcase
            end
            m_busy = acc;
        end
    end

    // Monitor: match each response against the scoreboard head in its due cycle.
    always @(negedge clk) begin : monitor_p
        exp_t e;
        if (ack) ack_cnt++;
        if (cyc_cnt > 1) begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc_cnt) begin
                e = sb_q.pop_front();
                checkOutput("resp_ack", 64'(ack), 64'(!e.is_err));
                checkOutput("resp_err", 64'(err), 64'(e.is_err));
                if (e.chk_dat) checkOutput("resp_dat", 64'(dat_o), 64'(e.dat));
                checkOutput("resp_reg_wr", 64'(reg_wr), 64'(e.wr));
            end else begin
                checkOutput("idle_quiet", 64'({ack, err, reg_wr, dat_o}), 64'h0);
            end
        end
    end

    task automatic checkRegs(input string name);
        logic [31:0] exp;
        for (int i = 0; i < NREGS; i++) begin
            case (mode_of(i))
                RO:      exp = hw_rd[i*32 +: 32];
                SHADOW:  exp = m_active[i];
                default: exp = m_stage[i];
            endcase
            checkOutput($sformatf("%s_regq%0d", name, i), 64'(reg_q[i*32 +: 32]), 64'(exp));
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic [NREGS*BUSW-1:0] set,
                                 input logic c);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        hw_set = set; commit = c;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; hw_set = '0; commit = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulseCommit();
        @(posedge clk); #1;
        commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
    endtask

    initial begin : main_p
        logic [NREGS*BUSW-1:0] set_v;
        logic [31:0]           a;
        int                    n0;
        int                    r;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ack_err", 64'({ack, err}), 64'h0);
        checkOutput("rst_dat", 64'(dat_o), 64'h0);
        checkOutput("rst_reg_wr", 64'(reg_wr), 64'h0);
        checkRegs("rst");
        rst_n = 1'b1;

        // Reset value readback of reg0
        applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, '0, 1'b0);
        checkOutput("reg0_reset", 64'(reg_q[31:0]), 64'h4000);

        // Byte-lane write to RW reg1, then a sel=0 write that changes nothing
        applyStimulus(1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101, '0, 1'b0);
        checkOutput("rw_bytelane", 64'(reg_q[63:32]), 64'h00BB_00DD);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'hF, '0, 1'b0);
        applyStimulus(1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000, '0, 1'b0);
        checkOutput("rw_sel0", 64'(reg_q[63:32]), 64'h00BB_00DD);

        // Out-of-range and misaligned accesses
        applyStimulus(1'b0, 32'(4*NREGS), 32'h0, 4'hF, '0, 1'b0);
        applyStimulus(1'b0, 32'h2, 32'h0, 4'hF, '0, 1'b0);
        applyStimulus(1'b1, 32'h6, 32'hFFFF_FFFF, 4'hF, '0, 1'b0);
        checkRegs("err");

        // W1C reg3: set and clear of bit 3 together, then a lone clear
        set_v = '0;
        set_v[3*32 + 3] = 1'b1;
        applyStimulus(1'b1, 32'hC, 32'h8, 4'hF, set_v, 1'b0);
        checkOutput("w1c_set_wins", 64'(reg_q[127:96]), 64'hF8);
        applyStimulus(1'b0, 32'hC, 32'h0, 4'hF, '0, 1'b0);
        applyStimulus(1'b1, 32'hC, 32'h8, 4'hF, '0, 1'b0);
        checkOutput("w1c_clear", 64'(reg_q[127:96]), 64'hF0);
        applyStimulus(1'b0, 32'hC, 32'h0, 4'hF, '0, 1'b0);

        // SHADOW reg4: staging, commit, write+commit
        applyStimulus(1'b1, 32'h10, 32'h1234, 4'hF, '0, 1'b0);
        checkOutput("shadow_staged", 64'(reg_q[159:128]), 64'h0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, '0, 1'b0);
        pulseCommit();
        checkOutput("shadow_commit", 64'(reg_q[159:128]), 64'h1234);
        applyStimulus(1'b1, 32'h10, 32'h5678, 4'hF, '0, 1'b1);
        checkOutput("shadow_wr_commit", 64'(reg_q[159:128]), 64'h5678);

        // Held strobe for six cycles yields three acks
        n0 = ack_cnt;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h0;
        repeat (6) @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("held_stb_acks", 64'(ack_cnt - n0), 64'd3);

        // Reset while a response is showing
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h0;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
        checkOutput("ack_before_reset", 64'(ack), 64'h1);
        n0 = ack_cnt;
        #2 rst_n = 1'b0;
        #1 checkOutput("ack_dropped", 64'({ack, err, reg_wr, dat_o}), 64'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("no_ack_after_reset", 64'(ack_cnt - n0), 64'h0);
        checkRegs("post_rst");

        // Random traffic against the model
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NREGS; i++) hw_rd[i*32 +: 32] = $urandom;
            r = $urandom_range(0, 9);
            a = 32'(r * 4) | (32'($urandom_range(0, 15)) << 12);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            set_v = '0;
            if ($urandom_range(0, 3) == 0) set_v[$urandom_range(0, NREGS*BUSW-1)] = 1'b1;
            applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                          set_v, ($urandom_range(0, 7) == 0));
            if (k % 25 == 24) checkRegs("rand");
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", 64'(sb_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
